muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Multi-cycle multiply/divide resource with HI/LO registers, sequenced for the pipelined CPU's EX stage.
//  Accepts one MULT/MULTU/DIV/DIVU at a time and holds busy for a fixed latency.
//  Commits the result to HI/LO on completion and serves MTHI/MTLO writes and MFHI/MFLO reads.
//  The hazard unit stalls ID on (start | busy) when the ID instruction is a muldiv op.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU
//  DIV_CYCLES   10  busy cycles for DIV/DIVU
// PORTS
//  clk       in   1   system clock, rising edge
//  reset     in   1   asynchronous, active-high; clears all state
//  start     in   1   launch operation given by op (EX stage)
//  op        in   3   0=MULT 1=MULTU 2=DIV 3=DIVU; 4..7 reserved
//  a         in   32  rs operand
//  b         in   32  rt operand
//  hilo_we   in   2   01=write LO (MTLO), 10=write HI (MTHI), 00/11=none
//  wdata     in   32  MTHI/MTLO data
//  hilo_sel  in   1   read select: 1=HI, 0=LO
//  rdata     out  32  combinational HI or LO per hilo_sel
//  busy      out  1   operation in flight
//  done      out  1   one-cycle pulse on the cycle HI/LO take the new result
// BEHAVIOUR
//  Reset: HI=LO=0, busy=0, done=0, counter=0, FSM=IDLE; applies immediately, incl. mid-operation (result discarded).
//  FSM IDLE -> RUN on start with valid op; RUN -> IDLE when counter reaches 1; no other states.
//  start sampled at edge E0: operands latched and full result computed into pending regs at E0,
//   so later changes on a/b have no effect. Counter loaded with N (MULT_CYCLES or DIV_CYCLES).
//  busy=1 for exactly N cycles after E0. Pending result written to HI/LO at the edge ending the
//   last busy cycle (E0+N). done=1 in the cycle after that edge. busy and done never both 1.
//  start while busy=1: ignored (hazard unit guarantees absence; checked by assertion).
//  start with op 4..7: ignored, state unchanged.
//  MULT: {HI,LO} = signed 64-bit a*b. MULTU: unsigned 64-bit product.
//  DIV: LO = signed quotient truncated toward zero; HI = remainder with sign of dividend.
//   0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//  DIVU: unsigned quotient/remainder.
//  Divide by zero: busy still held DIV_CYCLES; HI/LO unchanged at commit; done still pulses.
//  hilo_we when IDLE: selected register takes wdata at the edge. When busy: ignored.
//  start and hilo_we in same IDLE cycle: register write applies at E0; commit at E0+N overwrites it.
//  rdata: current HI/LO register value; no bypass of pending result or same-cycle wdata.
// STRUCTURE
//  Shared package mdu_defs: op encodings (MD_MULT..MD_DIVU), hilo_we encodings,
//   MULT_CYCLES/DIV_CYCLES defaults; the controller and hazard_solver both import it.
//  One sub-module: muldiv_calc (combinational 32x32->64 product and quotient/remainder
//   incl. signed/zero-divisor rules); the sequencer owns the FSM, counter, pending and HI/LO regs.
// TESTING
//  MULT a=0xFFFFFFFE b=3 -> busy 5 cycles; then HI=0xFFFFFFFF LO=0xFFFFFFFA; done pulses once.
//  MULTU a=0xFFFFFFFF b=2 -> HI=0x00000001 LO=0xFFFFFFFE after exactly 5 busy cycles.
//  DIV a=-7 b=2 -> busy 10 cycles; LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU 7/0 -> HI/LO unchanged.
//  MTHI 0x1234 while busy -> HI unchanged; MTLO 0x55 when idle -> rdata(sel=0)=0x55 next cycle.
//  start MULT 3*4 with same-cycle MTLO 0x99 -> LO=0x99 until commit, then LO=12 HI=0.
//  reset asserted at busy cycle 3 of DIV -> busy=0, HI=LO=0 at once; no done pulse afterward.

Source files
------------

// File: rtl/mdu_defs.sv
// Shared definitions for the multiply/divide unit: op and HI/LO write
// encodings, default latencies and small decode helpers. Imported by the
// muldiv sequencer and the hazard solver.
package mdu_defs;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3
  } md_op_e;

  typedef enum logic [1:0] {
    HILO_WE_NONE = 2'b00,
    HILO_WE_LO   = 2'b01,
    HILO_WE_HI   = 2'b10,
    HILO_WE_BOTH = 2'b11   // treated as no write
  } hilo_we_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  // Ops 4..7 are reserved and must not launch anything.
  function automatic logic op_is_valid(input logic [2:0] op);
    return op <= 3'(MD_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == 3'(MD_DIV)) || (op == 3'(MD_DIVU));
  endfunction

endpackage

// File: rtl/muldiv_calc.sv
// Combinational arithmetic core: 32x32->64 product and 32-bit
// quotient/remainder, signed or unsigned. op[1]=divide, op[0]=unsigned.
// Signed divide works on magnitudes so that 0x80000000 / -1 wraps to
// 0x80000000 with remainder 0 instead of overflowing.
module muldiv_calc
  import mdu_defs::*;
(
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  logic        is_signed;
  logic [63:0] prod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Product and quotient/remainder, then select by operation class.
  always_comb begin
    is_signed = ~op[0];
    if (is_signed) begin
      prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    end else begin
      prod = {32'd0, a} * {32'd0, b};
    end

    a_neg  = is_signed & a[31];
    b_neg  = is_signed & b[31];
    a_mag  = a_neg ? (32'd0 - a) : a;
    b_mag  = b_neg ? (32'd0 - b) : b;
    div_zero = (b == 32'd0);
    // Avoid a divide by zero in the datapath; the result is discarded anyway.
    b_safe = div_zero ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    // Quotient truncates toward zero; remainder follows the dividend sign.
    quot   = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem    = a_neg ? (32'd0 - r_mag) : r_mag;

    if (op[1]) begin
      hi = rem;
      lo = quot;
    end else begin
      hi = prod[63:32];
      lo = prod[31:0];
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer for the EX stage. The result is
// computed when the op is accepted and parked in pending registers; a
// down-counter holds busy for the op's latency and the pending value is
// committed to HI/LO on the last busy edge, with done pulsing afterwards.
module muldiv_sequencer
  import mdu_defs::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  hilo_we,
  input  logic [31:0] wdata,
  input  logic        hilo_sel,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done
);

  localparam int CNT_W = 8;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_commit_q, pend_commit_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;

  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;
  logic             calc_div_zero;

  muldiv_calc u_calc (
    .op       (op[1:0]),
    .a        (a),
    .b        (b),
    .hi       (calc_hi),
    .lo       (calc_lo),
    .div_zero (calc_div_zero)
  );

  // Next-state: accept op / MTHI / MTLO when idle, count down and commit when running.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_hi_d     = pend_hi_q;
    pend_lo_d     = pend_lo_q;
    pend_commit_d = pend_commit_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    done_d        = 1'b0;

    if (state_q == ST_IDLE) begin
      // Register writes only land while idle; a same-cycle start is later
      // overwritten by its own commit.
      if (hilo_we == HILO_WE_LO) begin
        lo_d = wdata;
      end else if (hilo_we == HILO_WE_HI) begin
        hi_d = wdata;
      end
      if (start && op_is_valid(op)) begin
        state_d       = ST_RUN;
        cnt_d         = op_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        pend_hi_d     = calc_hi;
        pend_lo_d     = calc_lo;
        // Divide by zero still runs full length but leaves HI/LO alone.
        pend_commit_d = !(op_is_div(op) && calc_div_zero);
      end
    end else begin
      if (cnt_q == CNT_W'(1)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
        if (pend_commit_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      pend_hi_q     <= '0;
      pend_lo_q     <= '0;
      pend_commit_q <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pend_hi_q     <= pend_hi_d;
      pend_lo_q     <= pend_lo_d;
      pend_commit_q <= pend_commit_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      done_q        <= done_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign done  = done_q;
  assign rdata = hilo_sel ? hi_q : lo_q;

  // The hazard unit keeps new ops out of EX while one is in flight.
  a_no_start_while_busy: assert property (@(posedge clk) disable iff (reset) !(start && busy));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected commits
// and register snapshots into queues; a monitor compares them against DUT
// outputs on done pulses and on requested probes.
module tb_muldiv_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  hilo_we;
  logic [31:0] wdata;
  logic        hilo_sel;
  logic [31:0] rdata;
  logic        busy;
  logic        done;

  muldiv_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .hilo_we  (hilo_we),
    .wdata    (wdata),
    .hilo_sel (hilo_sel),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
    int          done_cyc;
    string       name;
  } op_exp_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    string       name;
  } probe_t;

  op_exp_t     op_q[$];
  probe_t      probe_q[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          done_seen = 0;
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end else begin
      passes++;
    end
  endtask

  // Reference behaviour straight from the arithmetic definitions.
  function automatic void model_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] hi0, input logic [31:0] lo0,
                                       output logic [31:0] hi, output logic [31:0] lo);
    longint          sp;
    longint unsigned up;
    longint          sq;
    longint          sr;
    hi = hi0;
    lo = lo0;
    case (o)
      3'd0: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        {hi, lo} = sp;
      end
      3'd1: begin
        up = 64'(x) * 64'(y);
        {hi, lo} = up;
      end
      3'd2: if (y != 32'd0) begin
        sq = longint'($signed(x)) / longint'($signed(y));
        sr = longint'($signed(x)) % longint'($signed(y));
        lo = sq[31:0];
        hi = sr[31:0];
      end
      3'd3: if (y != 32'd0) begin
        lo = x / y;
        hi = x % y;
      end
      default: ;
    endcase
  endfunction

  // Monitor: owns hilo_sel, reads both registers through rdata.
  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    hilo_sel = 1'b1;
    #1;
    h = rdata;
    hilo_sel = 1'b0;
    #1;
    l = rdata;
  endtask

  initial begin
    int          busy_run;
    logic [31:0] h;
    logic [31:0] l;
    op_exp_t     e;
    probe_t      p;
    busy_run = 0;
    hilo_sel = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) busy_run = 0;
      else if (busy) busy_run++;
      if (done) begin
        done_seen++;
        chk("done_has_pending_op", 64'(op_q.size() != 0), 64'd1);
        if (op_q.size() != 0) begin
          e = op_q.pop_front();
          read_hilo(h, l);
          chk({e.name, "_hi"}, 64'(h), 64'(e.hi));
          chk({e.name, "_lo"}, 64'(l), 64'(e.lo));
          chk({e.name, "_done_cycle"}, 64'(cyc), 64'(e.done_cyc));
          chk({e.name, "_busy_cycles"}, 64'(busy_run), 64'(e.n));
          chk({e.name, "_busy_with_done"}, 64'(busy), 64'd0);
          $display("op %-16s hi=%h lo=%h busy_cycles=%0d", e.name, h, l, busy_run);
        end
        busy_run = 0;
      end
      while (probe_q.size() != 0) begin
        p = probe_q.pop_front();
        read_hilo(h, l);
        chk({p.name, "_hi"}, 64'(h), 64'(p.hi));
        chk({p.name, "_lo"}, 64'(l), 64'(p.lo));
        chk({p.name, "_busy"}, 64'(busy), 64'(p.busy));
        $display("probe %-16s hi=%h lo=%h busy=%0b", p.name, h, l, busy);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_probe(input logic [31:0] h, input logic [31:0] l, input logic bz, input string nm);
    probe_t p;
    p.hi = h;
    p.lo = l;
    p.busy = bz;
    p.name = nm;
    probe_q.push_back(p);
  endtask

  // Idle MTHI/MTLO; value must be visible on rdata the next cycle.
  task automatic mt(input logic [1:0] we, input logic [31:0] wd, input string nm);
    hilo_we = we;
    wdata = wd;
    tick();
    hilo_we = 2'b00;
    if (we == 2'b01) model_lo = wd;
    else if (we == 2'b10) model_hi = wd;
    push_probe(model_hi, model_lo, 1'b0, nm);
    tick();
  endtask

  // Launch an op (optionally with a same-cycle register write, and a
  // register write attempted while busy), then wait for its completion.
  task automatic issue_op(input logic [2:0] o, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [1:0] we, input logic [31:0] wd,
                          input logic [1:0] bwe, input logic [31:0] bwd, input string nm);
    op_exp_t     e;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    bit          valid;
    int          base;
    bit          seen;
    valid  = (o < 3'd4);
    pre_hi = model_hi;
    pre_lo = model_lo;
    if (we == 2'b01) pre_lo = wd;
    else if (we == 2'b10) pre_hi = wd;
    start = 1'b1;
    op = o;
    a = ia;
    b = ib;
    hilo_we = we;
    wdata = wd;
    if (valid) begin
      model_result(o, ia, ib, pre_hi, pre_lo, e.hi, e.lo);
      e.n = (o >= 3'd2) ? 10 : 5;
      e.done_cyc = cyc + 1 + e.n;
      e.name = nm;
      op_q.push_back(e);
    end
    base = done_seen;
    tick();
    start = 1'b0;
    op = 3'($urandom);
    a = $urandom;
    b = $urandom;
    hilo_we = valid ? bwe : 2'b00;
    wdata = bwd;
    tick();
    hilo_we = 2'b00;
    push_probe(pre_hi, pre_lo, valid, {nm, "_hold"});
    tick();
    model_hi = pre_hi;
    model_lo = pre_lo;
    if (valid) begin
      seen = 0;
      for (int k = 0; k < 40; k++) begin
        if (done_seen != base) begin
          seen = 1;
          break;
        end
        tick();
      end
      chk({nm, "_completed"}, 64'(seen), 64'd1);
      model_hi = e.hi;
      model_lo = e.lo;
      tick();
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  ro;
    int          r;
    reset = 1'b1;
    start = 1'b0;
    op = 3'd0;
    a = 32'd0;
    b = 32'd0;
    hilo_we = 2'b00;
    wdata = 32'd0;
    push_probe(32'd0, 32'd0, 1'b0, "reset_state");
    tick();
    tick();
    reset = 1'b0;
    tick();

    issue_op(3'd0, 32'hFFFF_FFFE, 32'd3, 2'b00, 32'd0, 2'b00, 32'd0, "mult_neg2x3");
    chk("mult_neg2x3_spec_hi", 64'(model_hi), 64'hFFFF_FFFF);
    chk("mult_neg2x3_spec_lo", 64'(model_lo), 64'hFFFF_FFFA);
    issue_op(3'd1, 32'hFFFF_FFFF, 32'd2, 2'b00, 32'd0, 2'b00, 32'd0, "multu_max_x2");
    issue_op(3'd2, 32'hFFFF_FFF9, 32'd2, 2'b00, 32'd0, 2'b10, 32'h1234, "div_m7_2_mthi");
    chk("div_m7_2_spec_lo", 64'(model_lo), 64'hFFFF_FFFD);
    issue_op(3'd3, 32'd7, 32'd0, 2'b00, 32'd0, 2'b00, 32'd0, "divu_by_zero");
    mt(2'b01, 32'h55, "mtlo_idle");
    issue_op(3'd0, 32'd3, 32'd4, 2'b01, 32'h99, 2'b00, 32'd0, "mult3x4_mtlo");
    issue_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00, 32'd0, 2'b01, 32'hABCD, "div_min_m1");
    issue_op(3'd2, 32'd100, 32'd0, 2'b10, 32'hCAFE, 2'b00, 32'd0, "div_zero_mthi");
    issue_op(3'd5, 32'd9, 32'd9, 2'b00, 32'd0, 2'b00, 32'd0, "reserved_op5");

    // Reset in the third busy cycle of a DIV: everything clears, no done.
    mt(2'b10, 32'h1111_2222, "mthi_pre_reset");
    start = 1'b1;
    op = 3'd2;
    a = 32'hFFFF_FFF9;
    b = 32'd2;
    tick();
    start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    model_hi = 32'd0;
    model_lo = 32'd0;
    push_probe(32'd0, 32'd0, 1'b0, "reset_mid_div");
    tick();
    reset = 1'b0;
    repeat (15) tick();
    push_probe(32'd0, 32'd0, 1'b0, "after_abort");
    tick();

    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if (r < 2) begin
        mt((r == 0) ? 2'b01 : 2'b10, ra, $sformatf("rnd%0d_mt", i));
      end else begin
        ro = (r == 9) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        issue_op(ro, ra, rb, 2'($urandom), $urandom, 2'($urandom), $urandom,
                 $sformatf("rnd%0d_op%0d", i, ro));
      end
    end

    repeat (3) tick();
    chk("op_queue_drained", 64'(op_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
